// File: rtl/spi_flash_responder.sv
// SPI flash responder (mode 0, single-bit I/O).
// Answers READ (03h), READ STATUS (05h) and JEDEC ID (9Fh) from a flash
// master. Read data comes from an external memory through a req/ack
// prefetch port. All SPI pins are oversampled in the clk domain.
module spi_flash_responder #(
   parameter int unsigned ADDR_W   = 24,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flash_cs,
   input  logic              flash_sclk,
   input  logic              flash_mosi,
   output logic              flash_miso,
   input  logic [7:0]        status_in,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_STAT,
      S_ID,
      S_IGNORE
   } state_e;

   // Synchronizer and sclk edge-detect flops
   logic cs_meta_q, cs_sync_q;
   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic mosi_meta_q, mosi_sync_q;

   // Protocol state
   state_e            state_q, state_d;
   logic [4:0]        bitcnt_q, bitcnt_d;
   logic [22:0]       shift_q, shift_d;
   logic [7:0]        tx_q, tx_d;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              want_q, want_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [7:0]        buf_q, buf_d;
   logic              buf_vld_q, buf_vld_d;
   logic              discard_q, discard_d;
   logic              underrun_q, underrun_d;
   logic              armed_q, armed_d;
   logic [1:0]        settle_q, settle_d;

   logic        sclk_rise, sclk_fall, boundary, ack_fire;
   logic [23:0] shift_in;

   assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
   assign boundary  = sclk_fall & (bitcnt_q[2:0] == 3'd0);
   assign ack_fire  = mem_ack & req_q;
   assign shift_in  = {shift_q, mosi_sync_q};

   // Two-flop synchronizers for the SPI pins plus previous sclk for edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         cs_meta_q   <= flash_cs;
         cs_sync_q   <= cs_meta_q;
         sclk_meta_q <= flash_sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         mosi_meta_q <= flash_mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   // Protocol and fetch-port state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         want_q     <= 1'b0;
         req_q      <= 1'b0;
         req_addr_q <= '0;
         buf_q      <= '0;
         buf_vld_q  <= 1'b0;
         discard_q  <= 1'b0;
         underrun_q <= 1'b0;
         armed_q    <= 1'b0;
         settle_q   <= '0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         want_q     <= want_d;
         req_q      <= req_d;
         req_addr_q <= req_addr_d;
         buf_q      <= buf_d;
         buf_vld_q  <= buf_vld_d;
         discard_q  <= discard_d;
         underrun_q <= underrun_d;
         armed_q    <= armed_d;
         settle_q   <= settle_d;
      end
   end

   // Next-state: command decode, byte shifting and memory prefetch handshake
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      want_d     = want_q;
      req_d      = req_q;
      req_addr_d = req_addr_q;
      buf_d      = buf_q;
      buf_vld_d  = buf_vld_q;
      discard_d  = discard_q;
      underrun_d = 1'b0;
      armed_d    = armed_q;
      settle_d   = {settle_q[0], 1'b1};

      // cs only counts once it has been seen high after the synchronizer
      // has flushed, so a cs held low across reset release is ignored.
      if (settle_q[1] && cs_sync_q) armed_d = 1'b1;

      if (ack_fire) begin
         req_d     = 1'b0;
         discard_d = 1'b0;
         if (!discard_q) begin
            buf_d     = mem_rdata;
            buf_vld_d = 1'b1;
         end
      end
      // A fetch queued behind a still-outstanding request issues once it retires.
      if (want_q && !req_q) begin
         req_d      = 1'b1;
         req_addr_d = addr_q;
         want_d     = 1'b0;
      end

      if (state_q != S_IDLE && cs_sync_q) begin
         state_d    = S_IDLE;
         bitcnt_d   = '0;
         tx_d       = '0;
         idx_d      = '0;
         want_d     = 1'b0;
         buf_vld_d  = 1'b0;
         req_d      = req_q & ~ack_fire;
         req_addr_d = req_addr_q;
         discard_d  = req_q & ~ack_fire;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (armed_q && !cs_sync_q) begin
                  state_d  = S_CMD;
                  bitcnt_d = '0;
                  tx_d     = '0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  shift_d  = shift_in[22:0];
                  bitcnt_d = bitcnt_q + 5'd1;
                  if (bitcnt_q == 5'd7) begin
                     bitcnt_d = '0;
                     case (shift_in[7:0])
                        8'h03:   state_d = S_ADDR;
                        8'h05:   state_d = S_STAT;
                        8'h9F:   state_d = S_ID;
                        default: state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               if (sclk_rise) begin
                  shift_d  = shift_in[22:0];
                  bitcnt_d = bitcnt_q + 5'd1;
                  if (bitcnt_q == 5'd23) begin
                     bitcnt_d = '0;
                     addr_d   = shift_in[ADDR_W-1:0];
                     want_d   = 1'b1;
                     state_d  = S_DATA;
                  end
               end
            end
            S_DATA, S_STAT, S_ID: begin
               if (sclk_rise) bitcnt_d = {2'b00, bitcnt_q[2:0] + 3'd1};
               if (boundary) begin
                  if (state_q == S_STAT) begin
                     tx_d = status_in;
                  end else if (state_q == S_ID) begin
                     case (idx_q)
                        2'd0:    tx_d = JEDEC_ID[23:16];
                        2'd1:    tx_d = JEDEC_ID[15:8];
                        2'd2:    tx_d = JEDEC_ID[7:0];
                        default: tx_d = 8'h00;
                     endcase
                     if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
                  end else begin
                     // An ack landing on the boundary cycle still makes it in time.
                     if (buf_vld_q) begin
                        tx_d = buf_q;
                     end else if (ack_fire && !discard_q) begin
                        tx_d = mem_rdata;
                     end else begin
                        tx_d       = 8'hFF;
                        underrun_d = 1'b1;
                        discard_d  = discard_q | (req_q & ~ack_fire);
                     end
                     buf_vld_d = 1'b0;
                     addr_d    = addr_q + ADDR_W'(1);
                     want_d    = 1'b1;
                  end
               end else if (sclk_fall) begin
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign flash_miso = tx_q[7];
   assign mem_req    = req_q;
   assign mem_addr   = req_addr_q;
   assign busy       = ~cs_sync_q;
   assign underrun   = underrun_q;

endmodule
